// File: rtl/ad2s1210_pkg.sv
// Shared constants and state encoding for the AD2S1210 master configuration sequencer.
package ad2s1210_pkg;

  localparam logic [7:0] ADDR_EXC   = 8'h91;
  localparam logic [7:0] ADDR_CTRL  = 8'h92;
  localparam logic [7:0] ADDR_FAULT = 8'hFF;

  // One byte frame spans this many CLK_DIV-long steps, inter-frame gap included.
  localparam int unsigned FRAME_STEPS = 20;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_EXC_A,
    ST_EXC_D,
    ST_CTL_A,
    ST_CTL_D,
    ST_FLT_A,
    ST_FLT_D,
    ST_CHECK,
    ST_CLEAR,
    ST_DONE,
    ST_FAIL
  } cfg_state_e;

endpackage

// File: rtl/ad2s1210_spi_byte.sv
// One-byte serial frame engine: WR_N framing, SCLK generation, MSB-first shift out/in.
module ad2s1210_spi_byte
  import ad2s1210_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       CLK_IN,
  input  logic       RST,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] tx,
  input  logic       SDO,
  output logic [7:0] rx,
  output logic       done,
  output logic       WR_N,
  output logic       SCLK,
  output logic       SDI
);

  localparam int unsigned DC_W      = $clog2(CLK_DIV);
  localparam int unsigned ST_W      = $clog2(FRAME_STEPS + 1);
  localparam int unsigned LAST_BIT  = 16;
  localparam int unsigned GAP_START = 18;

  logic            busy;
  logic [DC_W-1:0] dc;
  logic [ST_W-1:0] st;
  logic [ST_W-1:0] ns;
  logic [7:0]      sr;
  logic            step_end;

  assign step_end = (dc == DC_W'(CLK_DIV - 1));
  assign ns       = st + ST_W'(1);
  assign SDI      = sr[7];

  // Steps 1..16 alternate SCLK low/high; odd steps capture SDO, even steps advance SDI.
  always_ff @(posedge CLK_IN or posedge RST) begin
    if (RST) begin
      busy <= 1'b0;
      dc   <= '0;
      st   <= '0;
      sr   <= '0;
      rx   <= '0;
      done <= 1'b0;
      WR_N <= 1'b1;
      SCLK <= 1'b1;
    end else if (abort) begin
      busy <= 1'b0;
      dc   <= '0;
      st   <= '0;
      sr   <= '0;
      done <= 1'b0;
      WR_N <= 1'b1;
      SCLK <= 1'b1;
    end else if (start) begin
      busy <= 1'b1;
      dc   <= '0;
      st   <= '0;
      sr   <= tx;
      done <= 1'b0;
      WR_N <= 1'b0;
      SCLK <= 1'b1;
    end else if (busy) begin
      done <= (st == ST_W'(FRAME_STEPS - 1)) && (dc == DC_W'(CLK_DIV - 2));
      if (step_end) begin
        dc <= '0;
        st <= ns;
        if (ns <= ST_W'(LAST_BIT)) begin
          SCLK <= ~ns[0];
          if (ns[0]) rx <= {rx[6:0], SDO};
          else       sr <= {sr[6:0], 1'b0};
        end
        if (ns == ST_W'(GAP_START))   WR_N <= 1'b1;
        if (ns == ST_W'(FRAME_STEPS)) busy <= 1'b0;
      end else begin
        dc <= dc + DC_W'(1);
      end
    end
  end

endmodule

// File: rtl/ad2s1210_cfg.sv
// Post-reset configuration and fault check of the master AD2S1210; gates slave release via MASTER_OK.
module ad2s1210_cfg
  import ad2s1210_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned SETTLE_CYC = 2000,
  parameter logic [7:0]  EXC_FREQ   = 8'h28,
  parameter logic [7:0]  CTRL_WORD  = 8'h7E,
  parameter int unsigned MAX_RETRY  = 3
) (
  input  logic       CLK_IN,
  input  logic       RST,
  input  logic       REST_master,
  input  logic       SDO,
  output logic       A0,
  output logic       A1,
  output logic       WR_N,
  output logic       SCLK,
  output logic       SDI,
  output logic       SAMPLE_N,
  output logic       MASTER_OK,
  output logic       CFG_FAIL,
  output logic [7:0] FAULT_CODE,
  output logic       BUSY
);

  localparam int unsigned CNT_W = $clog2(SETTLE_CYC + 2 * CLK_DIV + 1);
  localparam int unsigned RTY_W = $clog2(MAX_RETRY + 1);

  cfg_state_e       state;
  cfg_state_e       next_state;
  logic [CNT_W-1:0] cnt;
  logic [RTY_W-1:0] retry;
  logic             busy_q;
  logic             start_c;
  logic             abort_c;
  logic [7:0]       tx_c;
  logic [7:0]       rx;
  logic             done;

  assign A0   = busy_q;
  assign A1   = busy_q;
  assign BUSY = busy_q;

  always_ff @(posedge CLK_IN or posedge RST) begin
    if (RST) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next state, frame launch and byte selection; a dropped REST_master overrides everything but FAIL.
  always_comb begin
    next_state = state;
    tx_c       = 8'h00;
    abort_c    = !REST_master && (state != ST_FAIL);
    unique case (state)
      ST_IDLE:   if (REST_master) next_state = ST_SETTLE;
      ST_SETTLE: if (cnt == CNT_W'(SETTLE_CYC - 1)) next_state = ST_EXC_A;
      ST_EXC_A:  if (done) next_state = ST_EXC_D;
      ST_EXC_D:  if (done) next_state = ST_CTL_A;
      ST_CTL_A:  if (done) next_state = ST_CTL_D;
      ST_CTL_D:  if (done) next_state = ST_FLT_A;
      ST_FLT_A:  if (done) next_state = ST_FLT_D;
      ST_FLT_D:  if (done) next_state = ST_CHECK;
      ST_CHECK: begin
        if (FAULT_CODE == 8'h00)            next_state = ST_DONE;
        else if (retry < RTY_W'(MAX_RETRY)) next_state = ST_CLEAR;
        else                                next_state = ST_FAIL;
      end
      ST_CLEAR:  if (cnt == CNT_W'(2 * CLK_DIV - 1)) next_state = ST_SETTLE;
      default:   next_state = state;
    endcase
    if (abort_c) next_state = ST_IDLE;

    case (next_state)
      ST_EXC_A: tx_c = ADDR_EXC;
      ST_EXC_D: tx_c = EXC_FREQ;
      ST_CTL_A: tx_c = ADDR_CTRL;
      ST_CTL_D: tx_c = CTRL_WORD;
      ST_FLT_A: tx_c = ADDR_FAULT;
      default:  tx_c = 8'h00;
    endcase
    start_c = (next_state inside {ST_EXC_A, ST_EXC_D, ST_CTL_A, ST_CTL_D, ST_FLT_A, ST_FLT_D})
              && (next_state != state);
  end

  // Registered outputs and counters, all decoded from the upcoming state.
  always_ff @(posedge CLK_IN or posedge RST) begin
    if (RST) begin
      cnt        <= '0;
      retry      <= '0;
      busy_q     <= 1'b0;
      SAMPLE_N   <= 1'b1;
      MASTER_OK  <= 1'b0;
      CFG_FAIL   <= 1'b0;
      FAULT_CODE <= 8'h00;
    end else begin
      cnt <= (next_state != state) ? '0 : cnt + CNT_W'(1);
      if (abort_c) retry <= '0;
      else if (state == ST_CHECK && next_state == ST_CLEAR) retry <= retry + RTY_W'(1);
      if (state == ST_FLT_D && next_state == ST_CHECK) FAULT_CODE <= rx;
      busy_q    <= !(next_state inside {ST_IDLE, ST_DONE, ST_FAIL});
      SAMPLE_N  <= (next_state != ST_CLEAR);
      MASTER_OK <= (next_state == ST_DONE);
      CFG_FAIL  <= (next_state == ST_FAIL);
    end
  end

  ad2s1210_spi_byte #(
    .CLK_DIV(CLK_DIV)
  ) u_spi (
    .CLK_IN(CLK_IN),
    .RST   (RST),
    .start (start_c),
    .abort (abort_c),
    .tx    (tx_c),
    .SDO   (SDO),
    .rx    (rx),
    .done  (done),
    .WR_N  (WR_N),
    .SCLK  (SCLK),
    .SDI   (SDI)
  );

endmodule

// File: tb/tb_ad2s1210_cfg.sv
// Bench for ad2s1210_cfg: converter model on the serial port, frame monitor, table and random runs.
module tb_ad2s1210_cfg;

  localparam int unsigned CLK_DIV    = 2;
  localparam int unsigned SETTLE_CYC = 16;
  localparam int          FIRST_LAT  = 1 + SETTLE_CYC + 6 * 20 * CLK_DIV + 1;
  localparam int          RETRY_LAT  = 2 * CLK_DIV + SETTLE_CYC + 6 * 20 * CLK_DIV + 1;

  logic       CLK_IN = 1'b0;
  logic       RST;
  logic       REST_master;
  logic       SDO;
  logic       A0, A1, WR_N, SCLK, SDI, SAMPLE_N, MASTER_OK, CFG_FAIL, BUSY;
  logic [7:0] FAULT_CODE;

  always #5 CLK_IN = ~CLK_IN;

  ad2s1210_cfg #(
    .CLK_DIV   (CLK_DIV),
    .SETTLE_CYC(SETTLE_CYC),
    .EXC_FREQ  (8'h28),
    .CTRL_WORD (8'h7E),
    .MAX_RETRY (3)
  ) dut (
    .CLK_IN     (CLK_IN),
    .RST        (RST),
    .REST_master(REST_master),
    .SDO        (SDO),
    .A0         (A0),
    .A1         (A1),
    .WR_N       (WR_N),
    .SCLK       (SCLK),
    .SDI        (SDI),
    .SAMPLE_N   (SAMPLE_N),
    .MASTER_OK  (MASTER_OK),
    .CFG_FAIL   (CFG_FAIL),
    .FAULT_CODE (FAULT_CODE),
    .BUSY       (BUSY)
  );

  typedef struct {
    logic [31:0] faults;
    logic        ok;
    logic [7:0]  code;
    int          clears;
    int          lat;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  vec_t        vecs[6];
  logic [7:0]  exp_b[6];
  logic [31:0] cur_faults;
  logic        prev_wr, prev_sclk, prev_sdi, prev_sn;
  int          lowcnt, falls, frame_cnt, snlow, clears;
  logic [7:0]  rbyte;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic mon_reset();
    prev_wr   = 1'b1;
    prev_sclk = 1'b1;
    prev_sdi  = 1'b0;
    prev_sn   = 1'b1;
    lowcnt    = 0;
    falls     = 8;
    frame_cnt = 0;
    snlow     = 0;
    clears    = 0;
    rbyte     = 8'h00;
    SDO       = 1'b0;
  endtask

  // Per-cycle frame checker plus converter model driving the fault byte onto SDO.
  task automatic mon_step();
    int         idx;
    logic [7:0] fb;
    if (RST || !REST_master) begin
      mon_reset();
    end else begin
      chk("ok_fail_exclusive", 32'(MASTER_OK & CFG_FAIL), 32'd0);
      if (!WR_N) begin
        if (prev_wr) begin
          chk("sclk_high_at_wr_fall", 32'(SCLK), 32'd1);
          lowcnt = 1;
          falls  = 0;
          rbyte  = 8'h00;
        end else begin
          lowcnt++;
        end
        if (prev_sclk && !SCLK) begin
          chk("sdi_stable_at_fall", 32'(SDI), 32'(prev_sdi));
          rbyte = {rbyte[6:0], SDI};
          falls++;
        end
      end else if (!prev_wr) begin
        chk("wr_low_cycles", 32'(lowcnt), 32'd36);
        chk("sclk_falls", 32'(falls), 32'd8);
        chk("sdi_byte", 32'(rbyte), 32'(exp_b[frame_cnt % 6]));
        frame_cnt++;
      end
      if (!SAMPLE_N) begin
        snlow++;
      end else if (!prev_sn) begin
        chk("clear_width", 32'(snlow), 32'(2 * CLK_DIV));
        clears++;
        snlow = 0;
      end
    end
    prev_wr   = WR_N;
    prev_sclk = SCLK;
    prev_sdi  = SDI;
    prev_sn   = SAMPLE_N;
    idx = frame_cnt / 6;
    if (idx > 3) idx = 3;
    fb  = cur_faults[31 - 8 * idx -: 8];
    SDO = (falls < 8) ? fb[7 - falls] : 1'b0;
  endtask

  task automatic tick();
    @(posedge CLK_IN);
    #1;
    mon_step();
  endtask

  task automatic do_reset();
    RST = 1'b1;
    REST_master = 1'b0;
    repeat (2) tick();
    RST = 1'b0;
    tick();
  endtask

  // Reference: reads continue until a clean byte or four reads; each retry costs one clear and a full pass.
  task automatic model(input logic [31:0] f, output logic ok, output logic [7:0] code,
                       output int clr, output int lat);
    logic found;
    found = 1'b0;
    ok    = 1'b0;
    code  = f[7:0];
    clr   = 3;
    for (int i = 0; i < 4; i++) begin
      if (!found && f[31 - 8 * i -: 8] == 8'h00) begin
        found = 1'b1;
        ok    = 1'b1;
        code  = 8'h00;
        clr   = i;
      end
    end
    lat = FIRST_LAT + RETRY_LAT * clr;
  endtask

  task automatic run_case(input string tag, input logic [31:0] faults, input logic exp_ok,
                          input logic [7:0] exp_code, input int exp_clr, input int exp_lat);
    int n;
    int frames_at_end;
    cur_faults  = faults;
    REST_master = 1'b1;
    n = 0;
    while (n < 3000) begin
      tick();
      n++;
      if (n == 1) chk({tag, " cfg_mode_entry"}, 32'({A0, A1, BUSY}), 32'b111);
      if (MASTER_OK || CFG_FAIL) break;
    end
    chk({tag, " outcome_seen"}, 32'(MASTER_OK | CFG_FAIL), 32'd1);
    chk({tag, " latency"}, 32'(n), 32'(exp_lat));
    chk({tag, " master_ok"}, 32'(MASTER_OK), 32'(exp_ok));
    chk({tag, " cfg_fail"}, 32'(CFG_FAIL), 32'(!exp_ok));
    chk({tag, " fault_code"}, 32'(FAULT_CODE), 32'(exp_code));
    chk({tag, " clear_pulses"}, 32'(clears), 32'(exp_clr));
    chk({tag, " frames"}, 32'(frame_cnt), 32'(6 * (exp_clr + 1)));
    chk({tag, " bus_released"}, 32'({A0, A1, BUSY}), 32'd0);
    frames_at_end = frame_cnt;
    repeat (20) tick();
    chk({tag, " outcome_sticky"}, 32'({MASTER_OK, CFG_FAIL}), 32'({exp_ok, !exp_ok}));
    chk({tag, " no_more_frames"}, 32'(frame_cnt), 32'(frames_at_end));
  endtask

  initial begin
    logic [31:0] f;
    logic        m_ok;
    logic [7:0]  m_code;
    int          m_clr, m_lat, n;

    exp_b = '{8'h91, 8'h28, 8'h92, 8'h7E, 8'hFF, 8'h00};
    vecs[0] = '{32'h00000000, 1'b1, 8'h00, 0, 258};
    vecs[1] = '{32'h40000000, 1'b1, 8'h00, 1, 519};
    vecs[2] = '{32'hFFFFFFFF, 1'b0, 8'hFF, 3, 1041};
    vecs[3] = '{32'h01800000, 1'b1, 8'h00, 2, 780};
    vecs[4] = '{32'h12345678, 1'b0, 8'h78, 3, 1041};
    vecs[5] = '{32'hAA000000, 1'b1, 8'h00, 1, 519};

    RST = 1'b1;
    REST_master = 1'b0;
    cur_faults = 32'h0;
    mon_reset();
    tick();
    chk("reset_outputs", 32'({A0, A1, WR_N, SCLK, SDI, SAMPLE_N, MASTER_OK, CFG_FAIL, BUSY}),
        32'b001101000);
    chk("reset_fault_code", 32'(FAULT_CODE), 32'd0);
    RST = 1'b0;
    repeat (3) tick();
    chk("idle_without_rest", 32'({BUSY, WR_N}), 32'b01);

    for (int i = 0; i < 6; i++) begin
      do_reset();
      run_case($sformatf("vec%0d", i), vecs[i].faults, vecs[i].ok, vecs[i].code,
               vecs[i].clears, vecs[i].lat);
    end

    for (int i = 0; i < 6; i++) begin
      for (int b = 0; b < 4; b++)
        f[31 - 8 * b -: 8] = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      model(f, m_ok, m_code, m_clr, m_lat);
      do_reset();
      run_case($sformatf("rnd%0d", i), f, m_ok, m_code, m_clr, m_lat);
    end

    // Abort in the middle of the control-data frame, then restart.
    do_reset();
    cur_faults  = 32'h0;
    REST_master = 1'b1;
    n = 0;
    while (n < 2000 && !(frame_cnt == 3 && !WR_N && falls >= 3)) begin
      tick();
      n++;
    end
    chk("abort_reached_ctl_d", 32'(frame_cnt == 3 && !WR_N), 32'd1);
    REST_master = 1'b0;
    tick();
    chk("abort_outputs", 32'({WR_N, SCLK, A0, A1, BUSY, SDI, MASTER_OK, SAMPLE_N}), 32'b11000001);
    repeat (3) tick();
    chk("abort_stays_idle", 32'({WR_N, SCLK, BUSY}), 32'b110);
    run_case("restart", 32'h0, 1'b1, 8'h00, 0, FIRST_LAT);

    // Asynchronous reset pulse between edges during the fault read.
    do_reset();
    cur_faults  = 32'hFFFFFFFF;
    REST_master = 1'b1;
    n = 0;
    while (n < 2000 && !(frame_cnt == 5 && !WR_N && falls >= 2)) begin
      tick();
      n++;
    end
    chk("rst_reached_flt_d", 32'(frame_cnt == 5 && !WR_N), 32'd1);
    #1;
    RST = 1'b1;
    #1;
    chk("async_rst_outputs", 32'({A0, A1, WR_N, SCLK, SDI, SAMPLE_N, MASTER_OK, CFG_FAIL, BUSY}),
        32'b001101000);
    chk("async_rst_fault_code", 32'(FAULT_CODE), 32'd0);
    #1;
    chk("async_rst_sclk_held", 32'(SCLK), 32'd1);
    RST = 1'b0;
    mon_reset();
    run_case("after_rst", 32'h0, 1'b1, 8'h00, 0, FIRST_LAT);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
